key_schedule_seq: RTL and testbench
===================================

KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 SHALL have parameter ENABLE_192, default 1: 1 = AES-192 accepted, 0 = key_len 2'b01 rejected.
REQ-002 SHALL have parameter ENABLE_256, default 1: 1 = AES-256 accepted, 0 = key_len 2'b10 rejected.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request expansion; sampled only in IDLE.
REQ-006 SHALL have port key_len  input  2  2'b00=128 (Nk=4,Nr=10), 2'b01=192 (Nk=6,Nr=12), 2'b10=256 (Nk=8,Nr=14), 2'b11 invalid.
REQ-007 SHALL have port key_in  input  256  cipher key, MSB-aligned; w[0]=key_in[255:224]; unused LSBs ignored.
REQ-008 SHALL have port rk_ready  input  1  consumer accepts rk_out.
REQ-009 SHALL have port rk_valid  output  1  rk_out/rk_idx valid.
REQ-010 SHALL have port rk_out  output  128  round key r = {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
REQ-011 SHALL have port rk_idx  output  4  round number r of rk_out.
REQ-012 SHALL have port busy  output  1  high from start acceptance until done.
REQ-013 SHALL have port done  output  1  one-cycle pulse after final round key handshake.
REQ-014 SHALL have port err  output  1  one-cycle pulse on rejected start.

Function
REQ-015 SHALL implement states IDLE, EXPAND, DRAIN; IDLE->EXPAND on start with supported key_len; EXPAND->DRAIN after last word generated; DRAIN->IDLE on final handshake.
REQ-016 SHALL, on start in IDLE with key_len invalid or disabled by parameter, pulse err next cycle and remain IDLE.
REQ-017 SHALL capture key_in and key_len only at accepted start; later changes have no effect.
REQ-018 SHALL generate exactly one 32-bit word w[i] per non-stalled EXPAND cycle, i = 0 .. 4(Nr+1)-1 (44/52/60 words).
REQ-019 SHALL set w[i] = key word i for i<Nk; otherwise w[i] = w[i-Nk] ^ temp, temp = w[i-1], replaced by SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk] when i mod Nk = 0, or by SubWord(w[i-1]) when Nk=8 and i mod Nk = 4 (FIPS-197).
REQ-020 SHALL use Rcon MSB byte sequence 01,02,04,08,10,20,40,80,1B,36, lower 24 bits zero.
REQ-021 SHALL hold the last 8 words in a sliding window; no full-schedule storage.
REQ-022 SHALL accumulate words in a 4-word buffer; on the 4th word, load rk_out/rk_idx and set rk_valid if the output register is empty or being accepted that cycle.
REQ-023 SHALL stall word generation (state held, no word consumed) when the 4th word is due and rk_valid=1 and rk_ready=0.
REQ-024 SHALL hold rk_out and rk_idx stable while rk_valid=1 and rk_ready=0.
REQ-025 SHALL deassert rk_valid after handshake unless a new round key loads the same cycle.
REQ-026 SHALL, with start at edge E0 and rk_ready held high, assert rk_valid with round 0 after edge E4 and each subsequent round every 4 cycles.
REQ-027 SHALL raise busy the cycle after accepted start; clear busy and pulse done the cycle after the round-Nr handshake.
REQ-028 SHALL ignore start while busy=1 (no err, no restart).
REQ-029 SHALL accept a new start in the cycle after done.

Reset
REQ-030 SHALL, on rst assertion at any time including mid-expansion, asynchronously force state IDLE and rk_valid, rk_out, rk_idx, busy, done, err, word counter and buffers to 0.
REQ-031 SHALL produce no rk_valid after rst deassertion until a new accepted start.

Verification
REQ-032 SHALL verify AES-128 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 -> 11 keys, round 1 word 0 = a0fafe17, round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, done once.
REQ-033 SHALL verify AES-192 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> 13 keys, round 12 = e98ba06f 448c773c 8ecc7204 01002202.
REQ-034 SHALL verify AES-256 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 with random rk_ready -> 15 keys, correct values, rk_out stable during stalls, round 14 = fe4890d1 e6188d0b 046df344 706c631e.
REQ-035 SHALL verify ENABLE_256=0, start with key_len=2'b10 -> err pulse one cycle, busy=0, rk_valid=0; key_len=2'b11 -> err pulse.
REQ-036 SHALL verify rst asserted after round 5 handshake -> all outputs 0 immediately; new AES-128 start then yields round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
REQ-037 SHALL verify start pulsed while busy -> ignored, sequence completes unchanged.

Source files
------------

// File: rtl/key_schedule_seq.sv
// Sequential AES key expansion: one 32-bit schedule word per cycle,
// emitted as 128-bit round keys over a valid/ready handshake.
module key_schedule_seq #(
    parameter bit ENABLE_192 = 1'b1,
    parameter bit ENABLE_256 = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DRAIN
    } state_t;

    function automatic logic [7:0] f_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = f_xtime(x);
        end
        return p;
    endfunction

    // Inverse as x^254 by square-and-multiply, then the affine map.
    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 0; k < 7; k++) begin
            p = f_gmul(p, p);
            r = f_gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    state_t        r_state;
    logic [1:0]    r_len;
    logic [255:0]  r_key;
    logic [31:0]   r_win [0:7];
    logic [31:0]   r_buf [0:3];
    logic [5:0]    r_cnt;
    logic [2:0]    r_kpos;
    logic [7:0]    r_rcon;

    logic [2:0]    w_nk_m1;
    logic [5:0]    w_last;
    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_sub;
    logic [31:0]   w_temp;
    logic [31:0]   w_word;
    logic          w_is_key;
    logic          w_fourth;
    logic          w_stall;
    logic          w_adv;
    logic          w_load;
    logic          w_ok;

    always_comb begin
        w_nk_m1 = 3'd3;
        w_last  = 6'd43;
        if (r_len == 2'b01) begin
            w_nk_m1 = 3'd5;
            w_last  = 6'd51;
        end else if (r_len == 2'b10) begin
            w_nk_m1 = 3'd7;
            w_last  = 6'd59;
        end
    end

    assign w_prev = r_win[0];
    assign w_back = r_win[w_nk_m1];
    assign w_sub  = {f_sbox(w_prev[31:24]), f_sbox(w_prev[23:16]),
                     f_sbox(w_prev[15:8]),  f_sbox(w_prev[7:0])};

    assign w_is_key = (r_cnt <= {3'b000, w_nk_m1});

    always_comb begin
        w_temp = w_prev;
        if (r_kpos == 3'd0)
            w_temp = {w_sub[23:0], w_sub[31:24]} ^ {r_rcon, 24'h000000};
        else if (r_len == 2'b10 && r_kpos == 3'd4)
            w_temp = w_sub;
        w_word = w_is_key ? r_key[255:224] : (w_back ^ w_temp);
    end

    // Only the word completing a round key can stall.
    assign w_fourth = (r_cnt[1:0] == 2'b11);
    assign w_stall  = w_fourth && rk_valid && !rk_ready;
    assign w_adv    = (r_state == S_EXPAND) && !w_stall;
    assign w_load   = w_adv && w_fourth;

    assign w_ok = (key_len == 2'b00)
               || (key_len == 2'b01 && ENABLE_192)
               || (key_len == 2'b10 && ENABLE_256);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_len    <= 2'b00;
            r_key    <= '0;
            r_cnt    <= '0;
            r_kpos   <= '0;
            r_rcon   <= '0;
            rk_valid <= 1'b0;
            rk_out   <= '0;
            rk_idx   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int k = 0; k < 8; k++) r_win[k] <= '0;
            for (int k = 0; k < 4; k++) r_buf[k] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (w_load) begin
                rk_valid <= 1'b1;
                rk_out   <= {r_buf[0], r_buf[1], r_buf[2], w_word};
                rk_idx   <= r_cnt[5:2];
            end else if (rk_ready) begin
                rk_valid <= 1'b0;
            end

            if (w_adv) begin
                r_win[0] <= w_word;
                for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
                r_key <= {r_key[223:0], 32'h0};
                r_buf[r_cnt[1:0]] <= w_word;
                r_cnt <= r_cnt + 6'd1;
                r_kpos <= (r_kpos == w_nk_m1) ? 3'd0 : r_kpos + 3'd1;
                if (r_kpos == 3'd0 && !w_is_key)
                    r_rcon <= f_xtime(r_rcon);
            end

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_ok) begin
                            r_key   <= key_in;
                            r_len   <= key_len;
                            r_cnt   <= '0;
                            r_kpos  <= '0;
                            r_rcon  <= 8'h01;
                            busy    <= 1'b1;
                            r_state <= S_EXPAND;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_EXPAND: begin
                    if (w_adv && r_cnt == w_last)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (rk_valid && rk_ready) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Scoreboarded bench for key_schedule_seq against an independent
// FIPS-197 key expansion model and published round-key anchors.
`timescale 1ns/1ps
module tb_key_schedule_seq;

    localparam logic [255:0] K128 =
        {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 =
        {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start2;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         rk_ready = 1'b1;
    logic         rk_valid, busy, done, err;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid2, busy2, done2, err2;
    logic [127:0] rk_out2;
    logic [3:0]   rk_idx2;

    always #5 clk = ~clk;

    key_schedule_seq u_dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len),
        .key_in(key_in), .rk_ready(rk_ready), .rk_valid(rk_valid),
        .rk_out(rk_out), .rk_idx(rk_idx), .busy(busy), .done(done),
        .err(err)
    );

    key_schedule_seq #(.ENABLE_192(1'b1), .ENABLE_256(1'b0)) u_dut_n256 (
        .clk(clk), .rst(rst), .start(start2), .key_len(key_len),
        .key_in(key_in), .rk_ready(rk_ready), .rk_valid(rk_valid2),
        .rk_out(rk_out2), .rk_idx(rk_idx2), .busy(busy2), .done(done2),
        .err(err2)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    int           n_done = 0;
    int           n_err = 0;
    bit           rnd_mode = 1'b0;
    logic [127:0] got [0:15];
    logic [7:0]   sb [0:255];
    logic [31:0]  tw [0:59];

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Carry-less product followed by reduction mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] tmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'h11b << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (tmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = 8'h63;
            for (int i = 0; i < 8; i++)
                s[i] = s[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sb[a] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic model(input logic [1:0] len, input logic [255:0] key);
        int nk;
        int nr;
        logic [7:0]  rc;
        logic [31:0] t;
        nk = (len == 2'b01) ? 6 : (len == 2'b10) ? 8 : 4;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                tw[i] = key[255 - 32*i -: 32];
            end else begin
                t = tw[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = tmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                tw[i] = tw[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++)
            q.push_back({4'(r), tw[4*r], tw[4*r+1], tw[4*r+2], tw[4*r+3]});
    endtask

    task automatic wait_done(input int budget, input string tag);
        int c;
        c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, done, 1'b1);
    endtask

    initial forever begin
        @(posedge clk);
        #1 rk_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: scoreboard pops on handshake, stability on stalls.
    initial begin
        logic         prev_stall;
        logic [127:0] prev_out;
        logic [3:0]   prev_idx;
        exp_t         e;
        prev_stall = 1'b0;
        prev_out = '0;
        prev_idx = '0;
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (err) n_err++;
            if (prev_stall) begin
                chk("hold_valid", rk_valid, 1'b1);
                chk("hold_out", rk_out, prev_out);
                chk("hold_idx", rk_idx, prev_idx);
            end
            prev_stall = rk_valid && !rk_ready;
            prev_out = rk_out;
            prev_idx = rk_idx;
            if (rk_valid && rk_ready) begin
                chk("sb_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_idx", rk_idx, e.idx);
                    chk("sb_key", rk_out, e.key);
                end
                got[rk_idx] = rk_out;
            end
        end
    end

    initial begin
        logic any_v;
        int c;
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        key_len = 2'b00;
        key_in = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {rk_valid, busy, done, err, rk_idx}, '0);
        chk("rst_rkout", rk_out, '0);
        rst = 1'b0;

        // AES-128, ready held high, latency and cadence
        model(2'b00, K128);
        @(negedge clk);
        start = 1'b1;
        key_len = 2'b00;
        key_in = K128;
        @(posedge clk);
        #1 start = 1'b0;
        key_in = {8{32'hdeadbeef}};
        key_len = 2'b11;
        @(negedge clk);
        chk("busy_rise", busy, 1'b1);
        repeat (3) @(negedge clk);
        chk("valid_before_e4", rk_valid, 1'b0);
        @(negedge clk);
        chk("valid_after_e4", rk_valid, 1'b1);
        chk("r0_idx", rk_idx, 4'd0);
        chk("r0_key", rk_out, K128[255:128]);
        repeat (4) @(negedge clk);
        chk("r1_valid", {rk_valid, rk_idx}, {1'b1, 4'd1});
        chk("r1_w0", rk_out[127:96], 32'ha0fafe17);
        wait_done(300, "done128");
        chk("q128_empty", q.size(), 0);
        chk("r10_128", got[10], R10_128);
        chk("busy_clear", busy, 1'b0);

        // AES-192 started in the done cycle, stray start while busy
        model(2'b01, K192);
        start = 1'b1;
        key_len = 2'b01;
        key_in = K192;
        @(posedge clk);
        #1 start = 1'b0;
        chk("done_cnt128", n_done, 1);
        n_done = 0;
        @(negedge clk);
        chk("b2b_busy", busy, 1'b1);
        chk("done_fall", done, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        key_len = 2'b00;
        key_in = K128;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(400, "done192");
        chk("q192_empty", q.size(), 0);
        chk("r12_192", got[12], R12_192);
        @(posedge clk);
        #1 chk("done_cnt192", n_done, 1);
        chk("no_err_busy_start", n_err, 0);
        n_done = 0;

        // AES-256 with random back-pressure
        rnd_mode = 1'b1;
        model(2'b10, K256);
        @(negedge clk);
        start = 1'b1;
        key_len = 2'b10;
        key_in = K256;
        @(posedge clk);
        #1 start = 1'b0;
        key_in = '0;
        wait_done(2000, "done256");
        chk("q256_empty", q.size(), 0);
        chk("r14_256", got[14], R14_256);
        @(posedge clk);
        #1 chk("done_cnt256", n_done, 1);
        n_done = 0;
        rnd_mode = 1'b0;

        // Rejected starts
        @(negedge clk);
        start = 1'b1;
        key_len = 2'b11;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("err_len3", {err, busy, rk_valid}, 3'b100);
        @(negedge clk);
        chk("err_len3_fall", {err, busy}, 2'b00);
        start2 = 1'b1;
        key_len = 2'b10;
        @(posedge clk);
        #1 start2 = 1'b0;
        @(negedge clk);
        chk("err_n256", {err2, busy2, rk_valid2}, 3'b100);
        @(negedge clk);
        chk("err_n256_fall", {err2, busy2}, 2'b00);
        @(posedge clk);
        #1 chk("err_cnt", n_err, 1);

        // Reset mid-expansion, then restart
        model(2'b00, K128);
        @(negedge clk);
        start = 1'b1;
        key_len = 2'b00;
        key_in = K128;
        @(posedge clk);
        #1 start = 1'b0;
        c = 0;
        while (!(rk_valid && rk_ready && rk_idx == 4'd5) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("seen_r5", {rk_valid, rk_idx}, {1'b1, 4'd5});
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_mid_ctrl", {rk_valid, busy, done, err, rk_idx}, '0);
        chk("rst_mid_rkout", rk_out, '0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        any_v = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_v = any_v | rk_valid | busy;
        end
        chk("quiet_after_rst", any_v, 1'b0);
        n_done = 0;
        got[0] = '0;
        model(2'b00, K128);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(300, "done_restart");
        chk("restart_r0", got[0], K128[255:128]);
        chk("restart_q_empty", q.size(), 0);
        @(posedge clk);
        #1 chk("done_cnt_restart", n_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
